keypad_entry: RTL and testbench

Upstream control stage of the microwave timer chain. Collects BCD digits from the keypad encoder into a four-digit MM:SS entry buffer and presents them as parallel load data to the countdown digit counters. Issues the active-low load strobe and gates the 1 Hz tick into the chain's count enable. Sequences the cook cycle (entry, load, run, pause, done) against door state and the chain's all-zero indication.

---
 rtl/keypad_entry_if.sv | 27 ++
 rtl/keypad_entry.sv | 107 ++++++++++
 tb/tb_keypad_entry.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/keypad_entry_if.sv
// rtl/keypad_entry_if.sv - keypad and countdown-chain signal bundle for keypad_entry
interface keypad_entry_if;
  logic       key_valid;
  logic [3:0] key_code;
  logic       tick;
  logic       door_closed;
  logic       timer_zero;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       loadn;
  logic       en;
  logic       running;
  logic       done;
  logic       err;

  modport master (
    output key_valid, key_code, tick, door_closed, timer_zero,
    input  sec_ones, sec_tens, min_ones, min_tens, loadn, en, running, done, err
  );

  modport slave (
    input  key_valid, key_code, tick, door_closed, timer_zero,
    output sec_ones, sec_tens, min_ones, min_tens, loadn, en, running, done, err
  );
endinterface

// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - MM:SS keypad entry buffer and cook-cycle sequencer
module keypad_entry #(
  parameter logic [3:0] KEY_START = 4'hA,
  parameter logic [3:0] KEY_STOP  = 4'hB
) (
  input  logic          clk,
  input  logic          clr,
  keypad_entry_if.slave kp
);

  typedef enum logic [2:0] {IDLE, ENTRY, LOAD, RUN, PAUSE, DONE} state_t;

  state_t      state, state_nx;
  logic [15:0] dbuf, dbuf_nx;   // {min_tens, min_ones, sec_tens, sec_ones}
  logic [2:0]  ndig, ndig_nx;
  logic        err_nx;
  logic        loadn_q, running_q, done_q, err_q;

  logic is_start, is_stop, is_digit;
  assign is_start = kp.key_valid && (kp.key_code == KEY_START);
  assign is_stop  = kp.key_valid && (kp.key_code == KEY_STOP);
  assign is_digit = kp.key_valid && (kp.key_code <= 4'd9) && !is_start && !is_stop;

  always_comb begin
    state_nx = state;
    dbuf_nx  = dbuf;
    ndig_nx  = ndig;
    err_nx   = 1'b0;
    case (state)
      IDLE, ENTRY: begin
        if (is_digit) begin
          if (ndig != 3'd4) begin
            dbuf_nx = {dbuf[11:0], kp.key_code};
            ndig_nx = ndig + 3'd1;
          end
          state_nx = ENTRY;
        end else if (state == ENTRY && is_stop) begin
          state_nx = IDLE;
          dbuf_nx  = 16'h0000;
          ndig_nx  = 3'd0;
        end else if (state == ENTRY && is_start) begin
          // an invalid seconds-tens digit is the only rejection that is flagged
          if (dbuf[7:4] > 4'd5)
            err_nx = 1'b1;
          else if (kp.door_closed && dbuf != 16'h0000)
            state_nx = LOAD;
        end
      end
      LOAD: state_nx = RUN;
      RUN: begin
        if (kp.timer_zero)
          state_nx = DONE;
        else if (is_stop || !kp.door_closed)
          state_nx = PAUSE;
      end
      PAUSE: begin
        if (is_start && kp.door_closed) begin
          state_nx = RUN;
        end else if (is_stop) begin
          state_nx = IDLE;
          dbuf_nx  = 16'h0000;
          ndig_nx  = 3'd0;
        end
      end
      DONE: begin
        if (kp.key_valid) begin
          state_nx = IDLE;
          dbuf_nx  = 16'h0000;
          ndig_nx  = 3'd0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= IDLE;
      dbuf      <= 16'h0000;
      ndig      <= 3'd0;
      loadn_q   <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_nx;
      dbuf      <= dbuf_nx;
      ndig      <= ndig_nx;
      loadn_q   <= (state_nx != LOAD);
      running_q <= (state_nx == RUN);
      done_q    <= (state_nx == DONE);
      err_q     <= err_nx;
    end
  end

  assign kp.min_tens = dbuf[15:12];
  assign kp.min_ones = dbuf[11:8];
  assign kp.sec_tens = dbuf[7:4];
  assign kp.sec_ones = dbuf[3:0];
  assign kp.loadn    = loadn_q;
  assign kp.running  = running_q;
  assign kp.done     = done_q;
  assign kp.err      = err_q;
  // tick passes straight through so the chain counts on the same cycle
  assign kp.en       = (state == RUN) && kp.tick && kp.door_closed;

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - randomized self-checking bench for keypad_entry
module tb_keypad_entry;
  localparam logic [3:0] K_START = 4'hA;
  localparam logic [3:0] K_STOP  = 4'hB;

  logic clk = 1'b0;
  logic clr;
  bit   door;
  bit   tz;

  keypad_entry_if kp();

  keypad_entry #(.KEY_START(K_START), .KEY_STOP(K_STOP)) dut (
    .clk (clk),
    .clr (clr),
    .kp  (kp.slave)
  );

  always #5 clk = ~clk;

  int    n_vec = 0;
  int    n_bad = 0;
  string m_phase;
  int    m_q[$];
  bit    m_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // digit position 0 = sec_ones ... 3 = min_tens; unfilled positions read 0
  function automatic int mdig(input int pos);
    if (pos < m_q.size()) return m_q[m_q.size() - 1 - pos];
    return 0;
  endfunction

  function automatic int mbuf();
    return mdig(3) * 4096 + mdig(2) * 256 + mdig(1) * 16 + mdig(0);
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_phase = "idle";
  endtask

  task automatic model_step(input bit c, input bit kv, input logic [3:0] kc, input bit dc, input bit z);
    bit st, sp, dg;
    m_err = 1'b0;
    if (c) begin
      model_clear();
      return;
    end
    st = kv && (kc == K_START);
    sp = kv && (kc == K_STOP);
    dg = kv && (kc <= 4'd9) && !st && !sp;
    if (m_phase == "idle" || m_phase == "entry") begin
      if (dg) begin
        if (m_q.size() < 4) m_q.push_back(int'(kc));
        m_phase = "entry";
      end else if (m_phase == "entry" && sp) begin
        model_clear();
      end else if (m_phase == "entry" && st) begin
        if (mdig(1) > 5) m_err = 1'b1;
        else if (dc && mbuf() != 0) m_phase = "load";
      end
    end else if (m_phase == "load") begin
      m_phase = "run";
    end else if (m_phase == "run") begin
      if (z) m_phase = "done";
      else if (sp || !dc) m_phase = "pause";
    end else if (m_phase == "pause") begin
      if (st && dc) m_phase = "run";
      else if (sp) model_clear();
    end else if (m_phase == "done") begin
      if (kv) model_clear();
    end
  endtask

  function automatic logic [15:0] dut_buf();
    return {kp.min_tens, kp.min_ones, kp.sec_tens, kp.sec_ones};
  endfunction

  // one clock: drive at the falling edge, check en before the edge, registers after it
  task automatic cyc(input bit kv, input logic [3:0] kc, input bit tk);
    kp.key_valid   = kv;
    kp.key_code    = kc;
    kp.tick        = tk;
    kp.door_closed = door;
    kp.timer_zero  = tz;
    #1;
    chk("en", kp.en, (m_phase == "run") && tk && door);
    @(posedge clk);
    model_step(clr, kv, kc, door, tz);
    @(negedge clk);
    chk("buf",     dut_buf(),  mbuf());
    chk("loadn",   kp.loadn,   m_phase != "load");
    chk("running", kp.running, m_phase == "run");
    chk("done",    kp.done,    m_phase == "done");
    chk("err",     kp.err,     m_err);
  endtask

  task automatic keys(input logic [15:0] k);
    for (int i = 3; i >= 0; i--) cyc(1'b1, k[i*4 +: 4], 1'b0);
  endtask

  initial begin
    logic [3:0] kc;
    int         r;
    door = 1'b1;
    tz   = 1'b0;
    clr  = 1'b1;
    kp.key_valid   = 1'b0;
    kp.key_code    = 4'h0;
    kp.tick        = 1'b0;
    kp.door_closed = 1'b1;
    kp.timer_zero  = 1'b0;
    m_err = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_buf",     dut_buf(),  16'h0000);
    chk("rst_loadn",   kp.loadn,   1'b1);
    chk("rst_running", kp.running, 1'b0);
    chk("rst_done",    kp.done,    1'b0);
    chk("rst_err",     kp.err,     1'b0);
    kp.tick = 1'b1;
    #1;
    chk("rst_en", kp.en, 1'b0);
    clr = 1'b0;

    cyc(1'b1, 4'd1, 1'b0);
    cyc(1'b1, 4'd3, 1'b0);
    cyc(1'b1, 4'd0, 1'b1);
    chk("tp1_buf",   dut_buf(), 16'h0130);
    chk("tp1_loadn", kp.loadn,  1'b1);
    cyc(1'b1, K_STOP, 1'b0);

    keys(16'h1300);
    cyc(1'b1, K_START, 1'b1);
    chk("tp2_loadn_low", kp.loadn, 1'b0);
    chk("tp2_data",      dut_buf(), 16'h1300);
    cyc(1'b0, 4'h0, 1'b1);
    chk("tp2_running",    kp.running, 1'b1);
    chk("tp2_loadn_high", kp.loadn,   1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 4'h0, i[0]);

    door = 1'b0;
    cyc(1'b0, 4'h0, 1'b1);
    chk("door_pause", kp.running, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    door = 1'b1;
    cyc(1'b1, K_START, 1'b0);
    chk("resume_run",   kp.running, 1'b1);
    chk("resume_loadn", kp.loadn,   1'b1);

    tz = 1'b1;
    cyc(1'b1, K_STOP, 1'b1);
    tz = 1'b0;
    chk("zero_done", kp.done, 1'b1);
    cyc(1'b1, 4'd7, 1'b0);
    chk("done_exit", kp.done,  1'b0);
    chk("done_buf",  dut_buf(), 16'h0000);

    keys(16'h0090);
    cyc(1'b1, K_START, 1'b0);
    chk("tp3_err", kp.err,    1'b1);
    chk("tp3_buf", dut_buf(), 16'h0090);
    cyc(1'b0, 4'h0, 1'b0);
    chk("tp3_err_clr", kp.err, 1'b0);
    cyc(1'b1, K_STOP, 1'b0);

    keys(16'h1234);
    cyc(1'b1, 4'd5, 1'b0);
    chk("five_buf", dut_buf(), 16'h1234);
    cyc(1'b1, K_START, 1'b0);
    cyc(1'b0, 4'h0, 1'b1);
    clr = 1'b1;
    cyc(1'b0, 4'h0, 1'b1);
    clr = 1'b0;
    chk("clr_running", kp.running, 1'b0);
    chk("clr_loadn",   kp.loadn,   1'b1);
    chk("clr_buf",     dut_buf(),  16'h0000);
    cyc(1'b0, 4'h0, 1'b1);

    for (int n = 0; n < 4000; n++) begin
      door = ($urandom_range(0, 7) != 0);
      tz   = ($urandom_range(0, 15) == 0);
      clr  = ($urandom_range(0, 299) == 0);
      r = $urandom_range(0, 9);
      if (r < 2)       kc = K_START;
      else if (r == 2) kc = K_STOP;
      else if (r == 3) kc = 4'($urandom_range(12, 15));
      else             kc = 4'($urandom_range(0, 9));
      cyc($urandom_range(0, 2) == 0, kc, $urandom_range(0, 3) == 0);
    end
    clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
